// File: rtl/fp_addsub.sv
// Parametrised IEEE-754 adder/subtractor, multi-cycle FSM with start/done handshake.
// Round-to-nearest-even with guard/round/sticky, gradual underflow, {invalid, overflow, inexact} flags.
module fp_addsub #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     op,
   input  logic [EXP_W+MAN_W:0]     a,
   input  logic [EXP_W+MAN_W:0]     b,
   output logic                     busy,
   output logic                     done,
   output logic [EXP_W+MAN_W:0]     sum,
   output logic [2:0]               flags
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int F   = MAN_W + 4;               // hidden, fraction, guard, round, sticky
   localparam int LZW = $clog2(F + 1);
   localparam int CW  = (EXP_W + 1 > LZW) ? EXP_W + 1 : LZW;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, OUT} state_t;

   state_t             state;
   logic [W-1:0]       a_q, b_q, res_q;
   logic [2:0]         rflags_q;
   logic               sx_q, sub_q, zero_q;
   logic [EXP_W-1:0]   ex_q;
   logic [F-1:0]       mx_q, my_q, m_q;
   logic [F:0]         mag_q;
   logic [EXP_W:0]     e_q;

   // operand classification straight off the input ports
   logic [W-1:0]       b_eff, spec_res;
   logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, special, spec_inv;

   always_comb begin
      b_eff   = {b[W-1] ^ op, b[W-2:0]};
      nan_a   = (a[W-2:MAN_W] == EMAX) && (a[MAN_W-1:0] != '0);
      nan_b   = (b[W-2:MAN_W] == EMAX) && (b[MAN_W-1:0] != '0);
      inf_a   = (a[W-2:MAN_W] == EMAX) && (a[MAN_W-1:0] == '0);
      inf_b   = (b[W-2:MAN_W] == EMAX) && (b[MAN_W-1:0] == '0);
      zero_a  = (a[W-2:0] == '0);
      zero_b  = (b[W-2:0] == '0);
      special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
      spec_res = '0;
      spec_inv = 1'b0;
      if (nan_a | nan_b | (inf_a & inf_b & (a[W-1] != b_eff[W-1]))) begin
         spec_res = QNAN;
         spec_inv = ~(nan_a | nan_b);
      end else if (inf_a)           spec_res = a;
      else if (inf_b)               spec_res = b_eff;
      else if (zero_a & zero_b)     spec_res = {a[W-1] & b_eff[W-1], {(W-1){1'b0}}};
      else if (zero_a)              spec_res = b_eff;
      else if (zero_b)              spec_res = a;
   end

   // alignment: larger magnitude becomes X, Y is shifted right with sticky collection
   logic               a_big;
   logic [W-1:0]       x, y;
   logic [EXP_W-1:0]   ex_eff, ey_eff;
   logic [31:0]        diff, sh;
   logic [F-1:0]       ym_full, xm, ym;
   logic [2*F-1:0]     wide;

   always_comb begin
      a_big   = a_q[W-2:0] >= b_q[W-2:0];
      x       = a_big ? a_q : b_q;
      y       = a_big ? b_q : a_q;
      ex_eff  = (x[W-2:MAN_W] == '0) ? EXP_W'(1) : x[W-2:MAN_W];
      ey_eff  = (y[W-2:MAN_W] == '0) ? EXP_W'(1) : y[W-2:MAN_W];
      xm      = {(x[W-2:MAN_W] != '0), x[MAN_W-1:0], 3'b000};
      ym_full = {(y[W-2:MAN_W] != '0), y[MAN_W-1:0], 3'b000};
      diff    = 32'(ex_eff) - 32'(ey_eff);
      sh      = (diff > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : diff;
      wide    = {ym_full, {F{1'b0}}} >> sh;
      ym      = {wide[2*F-1:F+1], wide[F] | (|wide[F-1:0])};
   end

   // normalisation: leading-one shift capped so the exponent never drops below 1
   logic [CW-1:0]      lz, cap, shn;
   logic [F-1:0]       nm_sh, nm;
   logic [EXP_W:0]     ne;

   always_comb begin
      lz = CW'(F);
      for (int i = 0; i < F; i++)
         if (mag_q[i]) lz = CW'(F - 1 - i);
      cap   = CW'(ex_q) - CW'(1);
      shn   = (lz > cap) ? cap : lz;
      nm_sh = mag_q[F-1:0] << shn;
      if (mag_q[F]) begin
         nm = {mag_q[F:2], mag_q[1] | mag_q[0]};
         ne = {1'b0, ex_q} + (EXP_W+1)'(1);
      end else begin
         nm = nm_sh;
         ne = nm_sh[F-1] ? ({1'b0, ex_q} - (EXP_W+1)'(shn)) : '0;
      end
   end

   // rounding to nearest even, then overflow to infinity
   logic               rg, rr, rs, inc, ovf;
   logic [MAN_W+1:0]   mant;
   logic [EXP_W:0]     ef;
   logic [MAN_W-1:0]   frac;
   logic [W-1:0]       rnd_res;
   logic [2:0]         rnd_flags;

   always_comb begin
      rg   = m_q[2];
      rr   = m_q[1];
      rs   = m_q[0];
      inc  = rg & (rr | rs | m_q[3]);
      mant = {1'b0, m_q[F-1:3]} + (MAN_W+2)'(inc);
      if (mant[MAN_W+1]) begin
         ef   = e_q + (EXP_W+1)'(1);
         frac = mant[MAN_W:1];
      end else if (mant[MAN_W]) begin
         ef   = (e_q == '0) ? (EXP_W+1)'(1) : e_q;
         frac = mant[MAN_W-1:0];
      end else begin
         ef   = '0;
         frac = mant[MAN_W-1:0];
      end
      ovf = ef >= {1'b0, EMAX};
      if (zero_q) begin
         rnd_res   = '0;
         rnd_flags = 3'b000;
      end else if (ovf) begin
         rnd_res   = {sx_q, EMAX, {MAN_W{1'b0}}};
         rnd_flags = 3'b011;
      end else begin
         rnd_res   = {sx_q, ef[EXP_W-1:0], frac};
         rnd_flags = {2'b00, rg | rr | rs};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         flags    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         rflags_q <= '0;
         sx_q     <= 1'b0;
         sub_q    <= 1'b0;
         zero_q   <= 1'b0;
         ex_q     <= '0;
         mx_q     <= '0;
         my_q     <= '0;
         mag_q    <= '0;
         m_q      <= '0;
         e_q      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start && !done) begin
               a_q      <= a;
               b_q      <= b_eff;
               res_q    <= spec_res;
               rflags_q <= {spec_inv, 2'b00};
               busy     <= 1'b1;
               state    <= special ? OUT : ALIGN;
            end
            ALIGN: begin
               sx_q  <= x[W-1];
               sub_q <= x[W-1] ^ y[W-1];
               ex_q  <= ex_eff;
               mx_q  <= xm;
               my_q  <= ym;
               state <= ADD;
            end
            ADD: begin
               mag_q <= sub_q ? ({1'b0, mx_q} - {1'b0, my_q}) : ({1'b0, mx_q} + {1'b0, my_q});
               state <= NORM;
            end
            NORM: begin
               m_q    <= nm;
               e_q    <= ne;
               zero_q <= (mag_q == '0);
               state  <= ROUND;
            end
            ROUND: begin
               res_q    <= rnd_res;
               rflags_q <= rnd_flags;
               state    <= OUT;
            end
            OUT: begin
               sum   <= res_q;
               flags <= rflags_q;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fp_addsub.sv
// Bench for fp_addsub: single-precision and half-precision instances, vector table plus
// scoreboard queue, with hand-written sequences for held start and reset mid-operation.
module tb_fp_addsub;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, op, busy, done;
   logic [31:0] a, b, sum;
   logic [2:0]  flags;
   logic        h_reset, h_start, h_op, h_busy, h_done;
   logic [15:0] h_a, h_b, h_sum;
   logic [2:0]  h_flags;

   fp_addsub dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .sum(sum), .flags(flags));

   fp_addsub #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .reset(h_reset), .start(h_start), .op(h_op), .a(h_a), .b(h_b),
      .busy(h_busy), .done(h_done), .sum(h_sum), .flags(h_flags));

   typedef struct {
      bit          half;
      logic [31:0] a, b;
      logic        op;
      logic [31:0] sum;
      logic [2:0]  flags;
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] sum;
      logic [2:0]  flags;
   } exp_t;

   vec_t tv[$];
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   nd = 0, h_nd = 0;

   always @(posedge clk) if (done)   nd   <= nd + 1;
   always @(posedge clk) if (h_done) h_nd <= h_nd + 1;

   function automatic void add(input bit hf, input logic [31:0] va, vb, input logic vo,
                               input logic [31:0] vs, input logic [2:0] vf, input int vl);
      vec_t v;
      v.half = hf; v.a = va; v.b = vb; v.op = vo; v.sum = vs; v.flags = vf; v.lat = vl;
      tv.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit hf, input logic [31:0] va, vb, input logic vo, vs);
      if (hf) begin h_a = va[15:0]; h_b = vb[15:0]; h_op = vo; h_start = vs; end
      else    begin a = va; b = vb; op = vo; start = vs; end
   endtask

   task automatic sample(input bit hf, output logic d, bz, output logic [31:0] s, output logic [2:0] f);
      if (hf) begin d = h_done; bz = h_busy; s = {16'h0, h_sum}; f = h_flags; end
      else    begin d = done;   bz = busy;   s = sum;            f = flags;   end
   endtask

   task automatic apply(input vec_t v, input string nm);
      int n, bcnt;
      logic d, bz;
      logic [31:0] s;
      logic [2:0] f;
      exp_t e;
      @(negedge clk);
      drive(v.half, v.a, v.b, v.op, 1'b1);
      e.sum = v.sum; e.flags = v.flags;
      sb_q.push_back(e);
      @(negedge clk);
      drive(v.half, ~v.a, ~v.b, ~v.op, 1'b0);   // operands must already be latched
      n = 0; bcnt = 0;
      sample(v.half, d, bz, s, f);
      while (!d && n < 20) begin
         if (bz) bcnt++;
         @(negedge clk);
         n++;
         sample(v.half, d, bz, s, f);
      end
      e = sb_q.pop_front();
      if (!d) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no done after %0d cycles", nm, n);
      end else begin
         chk({nm, "_lat"}, 32'(n), 32'(v.lat));
         chk({nm, "_busy"}, 32'(bcnt), 32'(v.lat));
         chk({nm, "_busy_at_done"}, {31'b0, bz}, 32'd0);
         chk({nm, "_sum"}, s, e.sum);
         chk({nm, "_flags"}, {29'b0, f}, {29'b0, e.flags});
      end
   endtask

   initial begin
      int n, nd0;
      exp_t e;
      reset = 1'b1; h_reset = 1'b1;
      start = 1'b0; op = 1'b0; a = '0; b = '0;
      h_start = 1'b0; h_op = 1'b0; h_a = '0; h_b = '0;

      // single precision
      add(0, 32'h3F800000, 32'h40000000, 0, 32'h40400000, 3'b000, 5);
      add(0, 32'h3F800000, 32'h3F800000, 1, 32'h00000000, 3'b000, 5);
      add(0, 32'h3F800000, 32'h33800000, 0, 32'h3F800000, 3'b001, 5);
      add(0, 32'h3F800001, 32'h33800000, 0, 32'h3F800002, 3'b001, 5);
      add(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 32'h7F800000, 3'b011, 5);
      add(0, 32'h7F800000, 32'h7F800000, 1, 32'h7FC00000, 3'b100, 1);
      add(0, 32'h00000001, 32'h00000001, 0, 32'h00000002, 3'b000, 5);
      add(0, 32'h007FFFFF, 32'h00000001, 0, 32'h00800000, 3'b000, 5);
      add(0, 32'h80000000, 32'h80000000, 0, 32'h80000000, 3'b000, 1);
      add(0, 32'h40400000, 32'h3F800000, 1, 32'h40000000, 3'b000, 5);
      add(0, 32'h3F800000, 32'h40000000, 1, 32'hBF800000, 3'b000, 5);
      add(0, 32'hC0000000, 32'h3F800000, 0, 32'hBF800000, 3'b000, 5);
      add(0, 32'h7F800001, 32'h3F800000, 0, 32'h7FC00000, 3'b000, 1);
      add(0, 32'h7F800000, 32'h7F800000, 0, 32'h7F800000, 3'b000, 1);
      add(0, 32'hFF800000, 32'h3F800000, 0, 32'hFF800000, 3'b000, 1);
      add(0, 32'h3F800000, 32'h7F800000, 1, 32'hFF800000, 3'b000, 1);
      add(0, 32'h00000000, 32'h80000000, 0, 32'h00000000, 3'b000, 1);
      add(0, 32'h80000000, 32'h00000000, 1, 32'h80000000, 3'b000, 1);
      add(0, 32'h00000000, 32'h3F800000, 1, 32'hBF800000, 3'b000, 1);
      add(0, 32'h40490FDB, 32'h00000000, 0, 32'h40490FDB, 3'b000, 1);
      add(0, 32'h3F800000, 32'h33C00000, 0, 32'h3F800001, 3'b001, 5);
      add(0, 32'h3F800000, 32'h33800000, 1, 32'h3F7FFFFF, 3'b000, 5);
      add(0, 32'h00800000, 32'h00000001, 1, 32'h007FFFFF, 3'b000, 5);
      add(0, 32'h3F800000, 32'h00000001, 0, 32'h3F800000, 3'b001, 5);
      add(0, 32'h7F7FFFFF, 32'h73000000, 0, 32'h7F800000, 3'b011, 5);
      // half precision
      add(1, 32'h3C00, 32'h3C00, 0, 32'h4000, 3'b000, 5);
      add(1, 32'h3C00, 32'h4000, 1, 32'hBC00, 3'b000, 5);
      add(1, 32'h7BFF, 32'h7BFF, 0, 32'h7C00, 3'b011, 5);
      add(1, 32'h0001, 32'h0001, 0, 32'h0002, 3'b000, 5);
      add(1, 32'h7C00, 32'h7C00, 1, 32'h7E00, 3'b100, 1);
      add(1, 32'h3C00, 32'h1000, 0, 32'h3C00, 3'b001, 5);

      repeat (3) @(negedge clk);
      reset = 1'b0; h_reset = 1'b0;
      @(negedge clk);
      chk("rst_sum",   sum, 32'h0);
      chk("rst_flags", {29'b0, flags}, 32'h0);
      chk("rst_done",  {31'b0, done}, 32'h0);
      chk("rst_busy",  {31'b0, busy}, 32'h0);
      chk("rst_h_sum", {16'h0, h_sum}, 32'h0);
      chk("rst_h_busy", {31'b0, h_busy}, 32'h0);

      for (int i = 0; i < tv.size(); i++)
         apply(tv[i], $sformatf("v%0d", i));

      // start held high: a second op is accepted only after the done cycle
      @(negedge clk);
      a = 32'h3F800000; b = 32'h40000000; op = 1'b0; start = 1'b1;
      e.sum = 32'h40400000; e.flags = 3'b000; sb_q.push_back(e);
      @(negedge clk);
      a = 32'h40000000; b = 32'h40000000;
      e.sum = 32'h40800000; e.flags = 3'b000; sb_q.push_back(e);
      n = 0;
      while (!done && n < 30) begin @(negedge clk); n++; end
      e = sb_q.pop_front();
      chk("held_first_lat", 32'(n), 32'd5);
      chk("held_first_sum", sum, e.sum);
      @(negedge clk); n++;
      while (!done && n < 30) begin @(negedge clk); n++; end
      start = 1'b0;
      e = sb_q.pop_front();
      chk("held_second_lat", 32'(n), 32'd12);
      chk("held_second_sum", sum, e.sum);
      chk("held_second_flags", {29'b0, flags}, 32'h0);

      // reset while the half unit is in ADD abandons the operation
      nd0 = h_nd;
      @(negedge clk);
      h_a = 16'h3C00; h_b = 16'h4000; h_op = 1'b0; h_start = 1'b1;
      @(negedge clk);
      h_start = 1'b0;
      @(negedge clk);
      h_reset = 1'b1;
      @(negedge clk);
      h_reset = 1'b0;
      chk("mid_rst_sum",   {16'h0, h_sum}, 32'h0);
      chk("mid_rst_flags", {29'b0, h_flags}, 32'h0);
      chk("mid_rst_busy",  {31'b0, h_busy}, 32'h0);
      chk("mid_rst_done",  {31'b0, h_done}, 32'h0);
      apply(tv[25], "after_rst");
      repeat (10) @(negedge clk);
      chk("mid_rst_done_count", 32'(h_nd - nd0), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
